peripheral_msi_master_port_ahb3: RTL
====================================

// Module: peripheral_msi_master_port_ahb3
// PURPOSE
//  Upstream neighbour of each MSI slave port; one instance per AHB master.
//  Decodes the master's address phase to one of SLAVES slave ports and raises that port's HSEL.
//  Holds the master in wait states until the target slave port grants it.
//  Muxes the data-phase response back; answers unmapped addresses with a 2-cycle ERROR.
//  Drives can_switch, which tells every slave port when it may re-arbitrate away from this master.
// PARAMETERS
//  PLEN    64  address width
//  XLEN    64  data width
//  SLAVES  5   number of slave ports reachable from this master
// PORTS
//  HCLK            in   1            clock
//  HRESET          in   1            synchronous reset, active-high
//  mst_HSEL        in   1            AHB master-side select
//  mst_HADDR       in   PLEN         address
//  mst_HWDATA      in   XLEN         write data (data phase)
//  mst_HRDATA      out  XLEN         read data to master
//  mst_HWRITE/HSIZE[3]/HBURST[3]/HPROT[4]/HTRANS[2]/HMASTLOCK  in   master control
//  mst_HREADY      in   1            bus HREADY seen by master
//  mst_HREADYOUT   out  1            ready to master
//  mst_HRESP       out  1            response to master (0 OKAY, 1 ERROR)
//  slv_base        in   SLAVES*PLEN  per-slave base address
//  slv_mask        in   SLAVES*PLEN  per-slave address mask
//  slvHSEL         out  SLAVES       one-hot select toward the slave ports
//  slvHADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK  out  shared fan-out
//  slvHREADY       out  1            HREADY toward slave ports (= mst_HREADYOUT)
//  slvHRDATA       in   SLAVES*XLEN  read data from each slave port
//  slvHREADYOUT    in   SLAVES       ready from each slave port
//  slvHRESP        in   SLAVES       response from each slave port
//  granted         in   SLAVES       bit s = 1 when slave port s grants this master
//  can_switch      out  1            slave ports may switch away from this master
// BEHAVIOUR
//  Reset (synchronous):
//  - state=IDLE, slvHSEL=0, slvHTRANS=IDLE, mst_HREADYOUT=1, mst_HRESP=0, can_switch=1, dsel=0.
//  - Reset asserted mid-transfer abandons the buffered phase; no response is completed.
//  Valid request: mst_HSEL & mst_HREADY & HTRANS in {NONSEQ, SEQ}.
//  - Decode: hit[s] = ((HADDR ^ slv_base[s]) & slv_mask[s]) == 0; lowest s wins; no hit = unmapped.
//  - IDLE/BUSY transfers: 0-wait OKAY; no slvHSEL.
//  FSM states: IDLE, PEND, DATA, ERR1, ERR2.
//  IDLE/DATA, valid request to slave s:
//  - granted[s]=1: address phase passed combinationally; dsel<=s; ->DATA.
//  - granted[s]=0: address/control captured into holding register; ->PEND.
//  PEND:
//  - Drive slvHSEL[s]=1 from the register; mst_HREADYOUT=0.
//  - A SEQ replayed from the register is forwarded as NONSEQ.
//  - When granted[s]=1 and slvHREADYOUT[s]=1, the phase is accepted: dsel<=s, ->DATA.
//  - Any number of wait cycles is allowed; the master is never dropped.
//  DATA:
//  - mst_HRDATA, mst_HREADYOUT and mst_HRESP = slvHRDATA/HREADYOUT/HRESP[dsel].
//  - slvHWDATA = mst_HWDATA.
//  - Exit ->IDLE when slvHREADYOUT[dsel]=1 and there is no new valid request.
//  Unmapped request:
//  - ->ERR1: HREADYOUT=0, HRESP=1. ->ERR2: HREADYOUT=1, HRESP=1. Then ->IDLE.
//  - The master's follow-on address phase (the one presented in ERR2) is ignored.
//  can_switch:
//  - 0 while the active or buffered phase has HMASTLOCK=1.
//  - 0 while the active or buffered phase has HTRANS in {SEQ, BUSY}.
//  - 0 in ERR1.
//  - Otherwise 1, including in PEND for a NONSEQ.
//  Back-to-back: a new address phase to slave t is accepted in the same cycle as
//  data-phase completion of dsel; dsel changes only when the accepted-phase HREADY is high.
//  A slave ERROR in DATA is passed through unchanged; this block adds no cycles.
// STRUCTURE
//  peripheral_msi_pkg holds:
//  - HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_SINGLE, HRESP_OKAY/ERROR;
//  - the state enum msi_mport_state_t.
//  Sub-module peripheral_msi_decoder_ahb3: combinational base/mask decode producing a one-hot
//  result plus a miss flag.
// TESTING
//  1. NONSEQ read 0x1000 to s1, granted[1]=1
//     -> slvHSEL=00010 same cycle; data returned next cycle; 0 wait.
//  2. Write to s2 with granted[2]=0 for 3 cycles
//     -> mst_HREADYOUT=0 for 3 cycles; slvHADDR stable; accepted in cycle 4 with NONSEQ.
//  3. INCR4 burst to s0 with HMASTLOCK=1
//     -> can_switch=0 for all 4 beats; returns to 1 after the last beat completes.
//  4. Access to an unmapped address
//     -> HREADYOUT 0 then 1, HRESP=1 both cycles; slvHSEL stays 0.
//  5. Back-to-back s0 then s3 transfers
//     -> dsel switches exactly at the s0 data-phase end; HRDATA comes from the correct port.
//  6. HRESET pulsed during PEND
//     -> next cycle all outputs at reset values; state=IDLE.

Source files
------------

// File: rtl/peripheral_msi_pkg.sv
// Shared AHB3 encodings and master-port FSM state type for the MSI interconnect.
package peripheral_msi_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PEND,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } msi_mport_state_t;

endpackage

// File: rtl/peripheral_msi_decoder_ahb3.sv
// Base/mask address decoder: one-hot hit on the lowest matching slave port, or a miss.
module peripheral_msi_decoder_ahb3 #(
  parameter int PLEN   = 64,
  parameter int SLAVES = 5,
  parameter int IDXW   = 3
) (
  input  logic [PLEN-1:0]        addr,
  input  logic [SLAVES*PLEN-1:0] base,
  input  logic [SLAVES*PLEN-1:0] mask,
  output logic [SLAVES-1:0]      hit,
  output logic [IDXW-1:0]        idx,
  output logic                   miss
);

  always_comb begin
    hit  = '0;
    idx  = '0;
    miss = 1'b1;
    for (int unsigned s = 0; s < SLAVES; s++) begin
      if (miss && (((addr ^ base[s*PLEN +: PLEN]) & mask[s*PLEN +: PLEN]) == '0)) begin
        hit[s] = 1'b1;
        idx    = IDXW'(s);
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/peripheral_msi_master_port_ahb3.sv
// Per-master MSI port: decodes, buffers ungranted address phases and muxes responses back.
module peripheral_msi_master_port_ahb3
  import peripheral_msi_pkg::*;
#(
  parameter int PLEN   = 64,
  parameter int XLEN   = 64,
  parameter int SLAVES = 5
) (
  input  logic                   HCLK,
  input  logic                   HRESET,

  input  logic                   mst_HSEL,
  input  logic [PLEN-1:0]        mst_HADDR,
  input  logic [XLEN-1:0]        mst_HWDATA,
  output logic [XLEN-1:0]        mst_HRDATA,
  input  logic                   mst_HWRITE,
  input  logic [2:0]             mst_HSIZE,
  input  logic [2:0]             mst_HBURST,
  input  logic [3:0]             mst_HPROT,
  input  logic [1:0]             mst_HTRANS,
  input  logic                   mst_HMASTLOCK,
  input  logic                   mst_HREADY,
  output logic                   mst_HREADYOUT,
  output logic                   mst_HRESP,

  input  logic [SLAVES*PLEN-1:0] slv_base,
  input  logic [SLAVES*PLEN-1:0] slv_mask,

  output logic [SLAVES-1:0]      slvHSEL,
  output logic [PLEN-1:0]        slvHADDR,
  output logic [XLEN-1:0]        slvHWDATA,
  output logic                   slvHWRITE,
  output logic [2:0]             slvHSIZE,
  output logic [2:0]             slvHBURST,
  output logic [3:0]             slvHPROT,
  output logic [1:0]             slvHTRANS,
  output logic                   slvHMASTLOCK,
  output logic                   slvHREADY,
  input  logic [SLAVES*XLEN-1:0] slvHRDATA,
  input  logic [SLAVES-1:0]      slvHREADYOUT,
  input  logic [SLAVES-1:0]      slvHRESP,

  input  logic [SLAVES-1:0]      granted,
  output logic                   can_switch
);

  localparam int IDXW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  msi_mport_state_t state, state_nxt;
  logic [IDXW-1:0]  dsel;
  logic             d_lock;

  logic [PLEN-1:0]  h_addr;
  logic             h_write, h_lock;
  logic [2:0]       h_size, h_burst;
  logic [3:0]       h_prot;
  logic [1:0]       h_trans;
  logic [IDXW-1:0]  h_sel;

  logic [SLAVES-1:0] dec_hit;
  logic [IDXW-1:0]   dec_idx;
  logic              dec_miss;
  logic req_valid, addr_st, take_direct, take_hold, take_err, pend_accept;

  peripheral_msi_decoder_ahb3 #(.PLEN(PLEN), .SLAVES(SLAVES), .IDXW(IDXW)) u_dec (
    .addr (mst_HADDR),
    .base (slv_base),
    .mask (slv_mask),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .miss (dec_miss)
  );

  assign req_valid   = mst_HSEL & mst_HREADY &
                       ((mst_HTRANS == HTRANS_NONSEQ) || (mst_HTRANS == HTRANS_SEQ));
  assign addr_st     = (state == ST_IDLE) || (state == ST_DATA);
  assign take_direct = addr_st & req_valid & ~dec_miss &  granted[dec_idx];
  assign take_hold   = addr_st & req_valid & ~dec_miss & ~granted[dec_idx];
  assign take_err    = addr_st & req_valid &  dec_miss;
  assign pend_accept = (state == ST_PEND) & granted[h_sel] & slvHREADYOUT[h_sel];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      dsel    <= '0;
      d_lock  <= 1'b0;
      h_addr  <= '0;
      h_write <= 1'b0;
      h_size  <= '0;
      h_burst <= HBURST_SINGLE;
      h_prot  <= '0;
      h_trans <= HTRANS_IDLE;
      h_lock  <= 1'b0;
      h_sel   <= '0;
    end else begin
      state <= state_nxt;
      if (take_direct) begin
        dsel   <= dec_idx;
        d_lock <= mst_HMASTLOCK;
      end else if (pend_accept) begin
        dsel   <= h_sel;
        d_lock <= h_lock;
      end
      if (take_hold) begin
        h_addr  <= mst_HADDR;
        h_write <= mst_HWRITE;
        h_size  <= mst_HSIZE;
        h_burst <= mst_HBURST;
        h_prot  <= mst_HPROT;
        h_trans <= mst_HTRANS;
        h_lock  <= mst_HMASTLOCK;
        h_sel   <= dec_idx;
      end
    end
  end

  // Address fan-out and next state; kept apart from the response mux so the
  // master's HREADY (often looped from mst_HREADYOUT) never feeds back on itself.
  always_comb begin
    state_nxt    = state;
    slvHSEL      = '0;
    slvHADDR     = mst_HADDR;
    slvHWDATA    = mst_HWDATA;
    slvHWRITE    = mst_HWRITE;
    slvHSIZE     = mst_HSIZE;
    slvHBURST    = mst_HBURST;
    slvHPROT     = mst_HPROT;
    slvHTRANS    = HTRANS_IDLE;
    slvHMASTLOCK = mst_HMASTLOCK;
    case (state)
      ST_IDLE, ST_DATA: begin
        if (take_direct) begin
          slvHSEL   = dec_hit;
          slvHTRANS = mst_HTRANS;
          state_nxt = ST_DATA;
        end else if (take_hold) begin
          state_nxt = ST_PEND;
        end else if (take_err) begin
          state_nxt = ST_ERR1;
        end else if ((state == ST_DATA) && slvHREADYOUT[dsel]) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_PEND: begin
        slvHSEL[h_sel] = 1'b1;
        slvHADDR       = h_addr;
        slvHWRITE      = h_write;
        slvHSIZE       = h_size;
        slvHBURST      = h_burst;
        slvHPROT       = h_prot;
        slvHTRANS      = (h_trans == HTRANS_SEQ) ? HTRANS_NONSEQ : h_trans;
        slvHMASTLOCK   = h_lock;
        if (pend_accept) state_nxt = ST_DATA;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mst_HREADYOUT = 1'b1;
    mst_HRESP     = HRESP_OKAY;
    mst_HRDATA    = '0;
    case (state)
      ST_DATA: begin
        mst_HREADYOUT = slvHREADYOUT[dsel];
        mst_HRESP     = slvHRESP[dsel];
        mst_HRDATA    = slvHRDATA[dsel*XLEN +: XLEN];
      end
      ST_PEND: mst_HREADYOUT = 1'b0;
      ST_ERR1: begin
        mst_HREADYOUT = 1'b0;
        mst_HRESP     = HRESP_ERROR;
      end
      ST_ERR2: mst_HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  assign slvHREADY = mst_HREADYOUT;

  always_comb begin
    can_switch = 1'b1;
    case (state)
      ST_IDLE, ST_DATA: begin
        if (mst_HSEL && (mst_HMASTLOCK || mst_HTRANS == HTRANS_SEQ || mst_HTRANS == HTRANS_BUSY))
          can_switch = 1'b0;
        if ((state == ST_DATA) && d_lock) can_switch = 1'b0;
      end
      ST_PEND:
        can_switch = !(h_lock || h_trans == HTRANS_SEQ || h_trans == HTRANS_BUSY);
      ST_ERR1: can_switch = 1'b0;
      default: ;
    endcase
  end

endmodule
